// File: rtl/seq_player.sv
// seq_player: plays back a latched sequence of up to eight 4-bit digits.
// Each digit is preceded by a blank gap and then shown for a fixed on-period.
// play_done is a level flag that stays high until the next start pulse.
module seq_player #(
    parameter int ON_CYCLES  = 25000000,
    parameter int OFF_CYCLES = 12500000,
    parameter int CNT_W      = 28
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_play,
    input  logic [31:0] answer_seq,
    input  logic [3:0]  seq_len,
    output logic [3:0]  digit_out,
    output logic        digit_valid,
    output logic [2:0]  digit_idx,
    output logic        play_done
);

    typedef enum logic [1:0] {
        P_IDLE,
        P_GAP,
        P_ON,
        P_DONE
    } state_t;

    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      seq_q;
    logic [2:0]       lastIdx_q;
    logic [2:0]       idx_q;
    logic [3:0]       digit_q;
    logic             valid_q;
    logic             done_q;
    logic [2:0]       lastIdx_d;

    // Clamp the requested length into an index of the final digit (0..7).
    always_comb begin
        lastIdx_d = 3'd0;
        if (seq_len == 4'd0) begin
            lastIdx_d = 3'd0;
        end else if (seq_len > 4'd8) begin
            lastIdx_d = 3'd7;
        end else begin
            lastIdx_d = 3'(seq_len - 4'd1);
        end
    end

    // Playback FSM; the shift register keeps the next digit in its top nibble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= P_IDLE;
            cnt_q     <= '0;
            seq_q     <= '0;
            lastIdx_q <= '0;
            idx_q     <= '0;
            digit_q   <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else if (start_play) begin
            state_q   <= P_GAP;
            cnt_q     <= '0;
            seq_q     <= answer_seq;
            lastIdx_q <= lastIdx_d;
            idx_q     <= '0;
            digit_q   <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                P_GAP: begin
                    if (cnt_q == OFF_LAST) begin
                        state_q <= P_ON;
                        cnt_q   <= '0;
                        valid_q <= 1'b1;
                        digit_q <= seq_q[31:28];
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                P_ON: begin
                    if (cnt_q == ON_LAST) begin
                        cnt_q   <= '0;
                        valid_q <= 1'b0;
                        digit_q <= '0;
                        if (idx_q == lastIdx_q) begin
                            state_q <= P_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= P_GAP;
                            idx_q   <= idx_q + 1'b1;
                            seq_q   <= seq_q << 4;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                P_IDLE, P_DONE: begin
                    state_q <= state_q;
                end
                default: begin
                    state_q <= P_IDLE;
                end
            endcase
        end
    end

    assign digit_out   = digit_q;
    assign digit_valid = valid_q;
    assign digit_idx   = idx_q;
    assign play_done   = done_q;

endmodule

// File: doc/seq_player.md
# seq_player

Sequence playback engine for the memory game. Responds to the game controller's `start_play` pulse by latching the 32-bit answer sequence and presenting it one 4-bit digit at a time. Each digit is shown for a fixed ON period, separated by blank gaps, on a digit bus that drives the 7-segment/LED display path. When the last digit finishes, it raises `play_done` and holds it until the next `start_play`.

## Interface
Parameters:
- `ON_CYCLES`, default 25000000: cycles each digit is displayed (0.5 s at 50 MHz). Must be ≥ 1.
- `OFF_CYCLES`, default 12500000: blank cycles before each digit (0.25 s at 50 MHz). Must be ≥ 1.
- `CNT_W`, default 28: width of the period counter. Must hold max(ON_CYCLES, OFF_CYCLES).

Ports:
- `clk` in 1: system clock. This block uses one clock.
- `rst_n` in 1: reset. Asynchronous and active-low.
- `start_play` in 1: one-cycle start pulse from the game controller.
- `answer_seq` in 32: sequence to play, eight 4-bit digits. Sampled only on `start_play`.
- `seq_len` in 4: number of digits to play. Sampled only on `start_play`.
- `digit_out` out 4: digit currently being shown. 4'h0 when not showing.
- `digit_valid` out 1: high while a digit is being shown. Low during gaps, idle, and done.
- `digit_idx` out 3: index of the current or upcoming digit.
- `play_done` out 1: level signal. Goes high after the last digit and stays high until the next `start_play` or reset.

## Operation
- Digit order is MSB first: digit k = `answer_seq[31-4k -: 4]`, for k = 0..7.
- Effective length N: `seq_len` = 0 plays 1 digit; `seq_len` > 8 plays 8; otherwise N = `seq_len`.
- States:
  - P_IDLE: state after reset. All outputs 0.
  - P_GAP: blank period before a digit.
  - P_ON: digit is displayed.
  - P_DONE: playback finished, `play_done` held high.
- Transitions:
  - Any state, `start_play`=1 → P_GAP. Actions: latch `answer_seq`, latch N, `digit_idx`←0, counter←0, `play_done`←0.
  - P_GAP, counter = OFF_CYCLES-1 → P_ON, counter←0.
  - P_ON, counter = ON_CYCLES-1, and `digit_idx` < N-1 → P_GAP, `digit_idx`+1.
  - P_ON, counter = ON_CYCLES-1, and `digit_idx` = N-1 → P_DONE, `play_done`←1.
  - P_DONE: stays in P_DONE. `digit_idx` holds N-1.
- `start_play` during P_GAP or P_ON aborts the current playback and restarts from digit 0 with the newly sampled inputs.
- Changes on `answer_seq` or `seq_len` while not starting are ignored.
- All outputs are registered.

## Timing
- Let E0 be the clock edge that samples `start_play`=1.
- `play_done` is 0 after E0. The controller samples `play_done` with `start_play` already low on the edge after E0, so it must see 0 there.
- `digit_valid` rises after edge E0+OFF_CYCLES and stays high for exactly ON_CYCLES cycles.
- Digit k is shown during cycles E0 + k·(ON+OFF) + OFF through E0 + (k+1)·(ON+OFF) - 1.
- `play_done` rises after edge E0 + N·(ON_CYCLES+OFF_CYCLES). `digit_valid` falls on that same edge.
- `digit_out` and `digit_valid` change on the same edge. `digit_out` is 0 whenever `digit_valid` = 0.
- Reset, including mid-playback: immediately P_IDLE, and `digit_out`=0, `digit_valid`=0, `digit_idx`=0, `play_done`=0, counter=0.
- In P_IDLE, `play_done`=0. The first `start_play` after reset must not see a stale done.
- The counter never exceeds max(ON,OFF)-1 and never wraps.

## Test plan
Use ON_CYCLES=4, OFF_CYCLES=2 for all scenarios.
1. Basic playback: `answer_seq`=32'h1234_5678, `seq_len`=4, pulse `start_play`.
   - `digit_out` shows 1, 2, 3, 4, each for 4 cycles with `digit_valid`=1, separated by 2-cycle gaps with `digit_valid`=0.
   - `play_done` rises exactly 24 cycles after E0 and holds.
2. Handshake: with `play_done`=1, pulse `start_play`.
   - `play_done` is 0 on the cycle after E0.
   - Changing `answer_seq` mid-play (e.g. to 32'hFFFF_FFFF) does not alter the played digits.
3. Length clamps:
   - `seq_len`=0 plays only digit 1 (from 32'h1234_5678); done at 6 cycles.
   - `seq_len`=12 plays all 8 digits 1..8; done at 48 cycles.
4. Restart: pulse `start_play` with 32'hAAAA_0000 during digit 2, then pulse again with 32'h9000_0000 and `seq_len`=1.
   - Playback restarts at digit_idx 0 and shows 9 after 2 gap cycles.
   - `play_done` reaches 1 only at 6 cycles after the second pulse.
5. Reset: assert `rst_n`=0 asynchronously mid-P_ON.
   - All outputs are 0 immediately, with no clock edge needed.
   - After release, the block idles until the next `start_play`.
